// File: rtl/parity_scan_pkg.sv
// Shared state encoding and segment constants for the parity scan controller.
package parity_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segment codes {g..a}
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/parity_seg_enc.sv
// Maps a nibble parity bit to its seven-segment glyph: odd -> 'O', even -> 'E'.
module parity_seg_enc
    import parity_scan_pkg::*;
(
    input  logic       par,
    output logic [6:0] seg
);

    assign seg = par ? SEG_O : SEG_E;

endmodule

// File: rtl/parity_scan_ctrl.sv
// Serial nibble-parity scanner driving one seven-segment digit per switch nibble.
// Optional total_odd output is enabled with macro PARITY_SCAN_TOTAL_EN.
module parity_scan_ctrl
    import parity_scan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLR_ON_START = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   sw,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done
`ifdef PARITY_SCAN_TOTAL_EN
    ,
    output logic                  total_odd
`endif
);

    localparam int NB = 4 * DIGITS;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_t              state;
    logic [NB-1:0]       shadow;
    logic [CW-1:0]       cnt;
    logic                acc;
    logic [7*DIGITS-1:0] hex_r;
    logic                par;
    logic [6:0]          seg;
`ifdef PARITY_SCAN_TOTAL_EN
    logic                total_r;
`endif

    // Parity of the current nibble including the bit being processed this edge
    assign par = acc ^ shadow[cnt];

    parity_seg_enc u_enc (
        .par (par),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            cnt    <= '0;
            acc    <= 1'b0;
            hex_r  <= '1;
`ifdef PARITY_SCAN_TOTAL_EN
            total_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        shadow <= sw;
                        cnt    <= '0;
                        acc    <= 1'b0;
                        if (CLR_ON_START != 0)
                            hex_r <= '1;
`ifdef PARITY_SCAN_TOTAL_EN
                        total_r <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    cnt <= cnt + CW'(1);
                    acc <= (cnt[1:0] == 2'b11) ? 1'b0 : par;
                    for (int unsigned k = 0; k < DIGITS; k++) begin
                        if (cnt == CW'(4 * k + 3))
                            hex_r[7*k +: 7] <= seg;
                    end
                    if (cnt == LAST) begin
                        state <= DONE;
`ifdef PARITY_SCAN_TOTAL_EN
                        total_r <= ^shadow;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hex  = hex_r;
    assign busy = (state == SCAN);
    assign done = (state == DONE);
`ifdef PARITY_SCAN_TOTAL_EN
    assign total_odd = total_r;
`endif

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Scoreboard bench for parity_scan_ctrl (DIGITS=4); checks total_odd when PARITY_SCAN_TOTAL_EN is defined.
module tb_parity_scan_ctrl;

    localparam int D  = 4;
    localparam int NB = 4 * D;
    localparam logic [6:0] G_O = 7'b1000000;
    localparam logic [6:0] G_E = 7'b0000110;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NB-1:0]   sw;
    logic [7*D-1:0]  hex;
    logic            busy;
    logic            done;
`ifdef PARITY_SCAN_TOTAL_EN
    logic            total_odd;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7*D-1:0] hex;
        logic           tot;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    parity_scan_ctrl #(.DIGITS(D), .CLR_ON_START(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sw        (sw),
        .hex       (hex),
        .busy      (busy),
        .done      (done)
`ifdef PARITY_SCAN_TOTAL_EN
        ,
        .total_odd (total_odd)
`endif
    );

    function automatic logic [7*D-1:0] model_hex(input logic [NB-1:0] s);
        logic [7*D-1:0] r;
        logic [3:0]     nib;
        r = '0;
        for (int k = 0; k < D; k++) begin
            nib = s[4*k +: 4];
            r[7*k +: 7] = (^nib) ? G_O : G_E;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [NB-1:0] s);
        exp_t e;
        e.hex = model_hex(s);
        e.tot = ^s;
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done=1 with no scan pending, hex=%b", hex);
            end else begin
                e = sbq.pop_front();
                if (hex !== e.hex) begin
                    failures++;
                    $display("FAIL result_hex: got %b expected %b", hex, e.hex);
                end
`ifdef PARITY_SCAN_TOTAL_EN
                checks++;
                if (total_odd !== e.tot) begin
                    failures++;
                    $display("FAIL total_odd: got %b expected %b", total_odd, e.tot);
                end
`endif
            end
        end
    end

    // Drive one start pulse and check busy length and the single done pulse
    task automatic do_scan(input logic [NB-1:0] s);
        int n;
        @(negedge clk);
        sw    = s;
        start = 1'b1;
        sbq.push_back(model(s));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != NB) begin
            failures++;
            $display("FAIL busy_len: got %0d cycles expected %0d", n, NB);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: done=%b expected 1", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_width: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        sw    = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (hex !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: hex=%b busy=%b done=%b expected all ones 0 0", hex, busy, done);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hex !== '1) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b hex=%b expected idle blank", busy, done, hex);
        end
    endtask

    task automatic test_basic();
        do_scan(16'h8F71);
        checks++;
        if (hex !== {G_O, G_E, G_O, G_O}) begin
            failures++;
            $display("FAIL basic_persist: got %b expected %b", hex, {G_O, G_E, G_O, G_O});
        end
    endtask

    task automatic test_extremes();
        do_scan(16'h0000);
        do_scan(16'hFFFF);
        checks++;
        if (hex !== {4{G_E}}) begin
            failures++;
            $display("FAIL extremes_persist: got %b expected %b", hex, {4{G_E}});
        end
    endtask

    task automatic test_ignore_start();
        int n;
        bit extra;
        @(negedge clk);
        sw    = 16'h0001;
        start = 1'b1;
        sbq.push_back(model(16'h0001));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hex !== '1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_on_start: hex=%b busy=%b expected blank 1", hex, busy);
        end
        repeat (5) @(negedge clk);
        sw    = 16'h1110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_done: no done within %0d cycles", n);
        end
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || sbq.size() != 0) begin
            failures++;
            $display("FAIL ignore_start: second_scan=%b pending=%0d expected 0 0", extra, sbq.size());
        end
        checks++;
        if (hex !== {G_E, G_E, G_E, G_O}) begin
            failures++;
            $display("FAIL ignore_result: got %b expected %b", hex, {G_E, G_E, G_E, G_O});
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        sw    = 16'h8F71;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (hex !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: hex=%b busy=%b done=%b expected blank 0 0", hex, busy, done);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_abort: activity after reset got 1 expected 0");
        end
        do_scan(16'h8F71);
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        sw    = 16'h0003;
        start = 1'b1;
        repeat (3) sbq.push_back(model(16'h0003));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (busy === 1'b1 && n < 200) begin
                n++;
                if (i == 2) start = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (n != NB || done !== 1'b1) begin
                failures++;
                $display("FAIL b2b_scan%0d: busy=%0d done=%b expected %0d 1", i, n, done, NB);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap%0d: busy=%b done=%b expected 0 0", i, busy, done);
            end
            if (i < 2) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart%0d: busy=%b expected 1", i, busy);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sbq.size() != 0 || hex[6:0] !== G_E) begin
            failures++;
            $display("FAIL b2b_end: busy=%b pending=%0d hex0=%b expected 0 0 %b", busy, sbq.size(), hex[6:0], G_E);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
